display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one `display7seg` decoder between DIGITS common-anode digits. Holds a frame-coherent display register loaded through a request/acknowledge handshake. Drives the decoder's `numero` input and the active-low digit anodes. Inserts a blanking gap between digits to suppress ghosting, and aligns anode enables with the decoder's one-cycle registered output.

---
 rtl/display_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller feeding a shared registered decoder.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   valor,
  input  logic                  load,
  output logic                  ack,
  output logic [3:0]            numero,
  output logic [DIGITS-1:0]     anodo,
  output logic                  frame_start
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLNK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  started_q, started_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d, shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  boundary, xfer;
  logic [3:0]            code;
  logic [DIGITS-1:0]     anodo_d;
  logic [3:0]            numero_q;
  logic [DIGITS-1:0]     anodo_q;
  logic                  ack_q, frame_start_q;

  // The first edge after reset only launches slot 0 of digit 0; counting
  // starts on the following edge so counters stay aligned with the outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    started_d = 1'b1;
    boundary  = 1'b0;
    if (started_q) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      case (state_q)
        BLANK: if (cnt_q == BLNK_LAST) state_d = SHOW;
        SHOW: if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  // A load landing on the frame boundary goes straight to disp.
  always_comb begin
    xfer      = boundary && (pending_q || load);
    disp_d    = xfer ? (load ? valor : shadow_q) : disp_q;
    shadow_d  = (load && !boundary) ? valor : shadow_q;
    pending_d = boundary ? 1'b0 : (load ? 1'b1 : pending_q);
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              run;
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run   = run && (disp_d[4*k +: 4] == 4'd0);
      lz[k] = run;
    end
  end
`endif

  // Decoder code and anode pattern for the cycle being launched.
  always_comb begin
    code = disp_d[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (lz[idx_d]) code = 4'b1011;
`endif
    anodo_d = '1;
    if (state_d == SHOW) anodo_d[idx_d] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      started_q     <= 1'b0;
      disp_q        <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      numero_q      <= 4'b1011;
      anodo_q       <= '1;
      ack_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      started_q     <= started_d;
      disp_q        <= disp_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      if (cnt_d == '0) numero_q <= code;
      anodo_q       <= anodo_d;
      ack_q         <= xfer;
      frame_start_q <= (cnt_d == '0) && (idx_d == '0);
    end
  end

  assign numero      = numero_q;
  assign anodo       = anodo_q;
  assign ack         = ack_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_display_scan_ctrl;
  localparam int D = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] valor = '0;
  logic        load  = 1'b0;
  logic        ack, frame_start;
  logic [3:0]  numero;
  logic [3:0]  anodo;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_disp   = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pend   = 1'b0;
  bit          m_ack    = 1'b0;
  logic [3:0]  sb[$];

  display_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clock(clock), .reset(reset), .valor(valor), .load(load), .ack(ack),
    .numero(numero), .anodo(anodo), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] exp_code(input logic [15:0] v, input int k);
    logic [15:0] upper;
    logic [3:0]  c;
    upper = v >> (4 * k);
    c     = upper[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && upper == 16'd0) c = 4'b1011;
`endif
    return c;
  endfunction

  // One full frame from its first cycle; optional loads after cycles l1c/l2c.
  task automatic frame_check(input int l1c, input logic [15:0] l1v,
                             input int l2c, input logic [15:0] l2v);
    logic [3:0] cur, ea;
    int s, p;
    cur = '0;
    for (int c = 0; c < D * P; c++) begin
      @(negedge clock);
      load = 1'b0;
      s = c / P;
      p = c % P;
      if (c == 0) for (int k = 0; k < D; k++) sb.push_back(exp_code(m_disp, k));
      if (p == 0) cur = sb.pop_front();
      ea = 4'hF;
      if (p >= B) ea[s] = 1'b0;
      total++;
      if (anodo !== ea) begin
        bad++; $display("FAIL anodo c=%0d got=%b exp=%b", c, anodo, ea);
      end
      total++;
      if (numero !== cur) begin
        bad++; $display("FAIL numero c=%0d got=%h exp=%h", c, numero, cur);
      end
      total++;
      if (frame_start !== (c == 0)) begin
        bad++; $display("FAIL frame_start c=%0d got=%b exp=%b", c, frame_start, c == 0);
      end
      total++;
      if (ack !== (c == 0 && m_ack)) begin
        bad++; $display("FAIL ack c=%0d got=%b exp=%b", c, ack, c == 0 && m_ack);
      end
      if (c == l1c) begin load = 1'b1; valor = l1v; m_shadow = l1v; m_pend = 1'b1; end
      if (c == l2c) begin load = 1'b1; valor = l2v; m_shadow = l2v; m_pend = 1'b1; end
    end
    if (m_pend) begin
      m_disp = m_shadow; m_pend = 1'b0; m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (anodo !== 4'hF) begin bad++; $display("FAIL %s anodo got=%b exp=1111", tag, anodo); end
    total++;
    if (numero !== 4'b1011) begin bad++; $display("FAIL %s numero got=%b exp=1011", tag, numero); end
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL %s ack got=%b exp=0", tag, ack); end
    total++;
    if (frame_start !== 1'b0) begin bad++; $display("FAIL %s frame_start got=%b exp=0", tag, frame_start); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    frame_check(-1, '0, -1, '0);
    frame_check(-1, '0, -1, '0);
  endtask

  task automatic test_load_mid();
    frame_check(10, 16'h4321, -1, '0);
    frame_check(-1, '0, -1, '0);
    frame_check(-1, '0, -1, '0);
  endtask

  task automatic test_back_to_back();
    frame_check(5, 16'h1111, 20, 16'h2222);
    frame_check(-1, '0, -1, '0);
    frame_check(-1, '0, -1, '0);
  endtask

  task automatic test_boundary_load();
    frame_check(D * P - 1, 16'h0A0B, -1, '0);
    frame_check(-1, '0, -1, '0);
    frame_check(-1, '0, -1, '0);
  endtask

  task automatic test_leading_zero();
    frame_check(12, 16'h0050, -1, '0);
    frame_check(-1, '0, -1, '0);
    frame_check(3, 16'h0000, -1, '0);
    frame_check(-1, '0, -1, '0);
  endtask

  // Reset during digit 2's SHOW with a load pending; it must be discarded.
  task automatic test_reset_mid();
    for (int c = 0; c <= 2 * P + 4; c++) begin
      @(negedge clock);
      load = 1'b0;
      if (c == 2 * P + 2) begin load = 1'b1; valor = 16'h9999; end
    end
    total++;
    if (anodo !== 4'b1011) begin bad++; $display("FAIL premid anodo got=%b exp=1011", anodo); end
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_disp = '0; m_shadow = '0; m_pend = 1'b0; m_ack = 1'b0;
    sb.delete();
    frame_check(-1, '0, -1, '0);
    frame_check(-1, '0, -1, '0);
  endtask

  initial begin
    test_reset();
    test_load_mid();
    test_back_to_back();
    test_boundary_load();
    test_leading_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
